// File: rtl/wb_port_arbiter_pkg.sv
// cpu_pkg: shared widths, requester IDs and output-stage state encoding for the writeback arbiter
package cpu_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_AW = 4;
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LD = 1'b1;
  localparam logic [0:0] OUT_EMPTY = 1'b0;
  localparam logic [0:0] OUT_FULL = 1'b1;
endpackage

// File: rtl/wb_port_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; req in, one-hot grant out, advance records the winner as last_grant
module rr_arb2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last_q;
  always_comb grant = (&req) ? ((last_q == REQ_LD) ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= REQ_LD;
    else if (advance && |req) last_q <= grant[1];
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the bank write port between ALU (req 0) and load (req 1) writebacks, one-entry output
// register with stall, plus a per-register pending scoreboard (pending_mask, reserve_conflict, wb_orphan pulses)
module wb_port_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [REG_AW-1:0]    alu_reg,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 ld_valid,
  input  logic [REG_AW-1:0]    ld_reg,
  input  logic [DATA_W-1:0]    ld_data,
  output logic                 ld_ready,
  input  logic                 wr_stall,
  output logic                 wr_en,
  output logic [REG_AW-1:0]    wr_reg,
  output logic [DATA_W-1:0]    wr_data,
  input  logic                 reserve_en,
  input  logic [REG_AW-1:0]    reserve_reg,
  input  logic                 flush,
  output logic [2**REG_AW-1:0] pending_mask,
  output logic                 reserve_conflict,
  output logic                 wb_orphan
);
  localparam int NR = 2 ** REG_AW;
  logic [0:0] state_q, state_d;
  logic [REG_AW-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NR-1:0] pend_q, pend_d, clr, set;
  logic conflict_q, conflict_d, orphan_q, orphan_d;
  logic can_accept, commit, accept;
  logic [1:0] grant;
  rr_arb2 u_arb (
    .clk(clk),
    .rst(rst),
    .req({ld_valid, alu_valid}),
    .advance(can_accept),
    .grant(grant)
  );
  always_comb begin
    can_accept = (state_q == OUT_EMPTY) || !wr_stall;
    commit = (state_q == OUT_FULL) && !wr_stall;
    alu_ready = can_accept && grant[0];
    ld_ready = can_accept && grant[1];
    accept = alu_ready || ld_ready;
    state_d = accept ? OUT_FULL : commit ? OUT_EMPTY : state_q;
    wr_reg_d = !accept ? wr_reg_q : ld_ready ? ld_reg : alu_reg;
    wr_data_d = !accept ? wr_data_q : ld_ready ? ld_data : alu_data;
    clr = commit ? (NR'(1) << wr_reg_q) : '0;
    set = reserve_en ? (NR'(1) << reserve_reg) : '0;
    // set is OR'd last so a same-cycle reserve beats both the commit clear and flush
    pend_d = (flush ? '0 : (pend_q & ~clr)) | set;
    conflict_d = reserve_en && pend_q[reserve_reg] && !flush && !(commit && wr_reg_q == reserve_reg);
    orphan_d = commit && !pend_q[wr_reg_q];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= OUT_EMPTY;
      wr_reg_q <= '0;
      wr_data_q <= '0;
      pend_q <= '0;
      conflict_q <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_reg_q <= wr_reg_d;
      wr_data_q <= wr_data_d;
      pend_q <= pend_d;
      conflict_q <= conflict_d;
      orphan_q <= orphan_d;
    end
  assign wr_en = (state_q == OUT_FULL);
  assign wr_reg = wr_reg_q;
  assign wr_data = wr_data_q;
  assign pending_mask = pend_q;
  assign reserve_conflict = conflict_q;
  assign wb_orphan = orphan_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: randomized scoreboard bench against a behavioural model of arbitration and the pending table
module tb_wb_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;
  logic clk = 1'b0, rst;
  logic alu_valid, alu_ready, ld_valid, ld_ready, wr_stall, wr_en;
  logic reserve_en, flush, reserve_conflict, wb_orphan;
  logic [AW-1:0] alu_reg, ld_reg, wr_reg, reserve_reg;
  logic [DW-1:0] alu_data, ld_data, wr_data;
  logic [NR-1:0] pending_mask;
  wb_port_arbiter #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready),
    .wr_stall(wr_stall), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .reserve_en(reserve_en), .reserve_reg(reserve_reg), .flush(flush),
    .pending_mask(pending_mask), .reserve_conflict(reserve_conflict), .wb_orphan(wb_orphan)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wr_t;
  wr_t exp_q[$];
  int n_chk = 0, n_err = 0;
  bit pend_m[NR];
  bit exp_orph, exp_conf, exp_ardy, exp_lrdy, last_ld, commit_f, mon_en, pl_a, pl_l, got_a, got_l;
  logic [AW-1:0] commit_r;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [NR-1:0] pend_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = pend_m[i];
    return v;
  endfunction
  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < NR; i++) pend_m[i] = 0;
    last_ld = 1;
    commit_f = 0;
    exp_orph = 0;
    exp_conf = 0;
    got_a = 0;
    got_l = 0;
  endtask
  always @(negedge clk) if (mon_en) begin
    chk("alu_ready", alu_ready, exp_ardy);
    chk("ld_ready", ld_ready, exp_lrdy);
    chk("wr_en", wr_en, exp_q.size() != 0);
    if (exp_q.size() != 0 && wr_en) begin
      chk("wr_reg", wr_reg, exp_q[0].r);
      chk("wr_data", wr_data, exp_q[0].d);
    end
    chk("pending_mask", pending_mask, pend_vec());
    chk("wb_orphan", wb_orphan, exp_orph);
    chk("reserve_conflict", reserve_conflict, exp_conf);
    commit_f = 0;
    if (exp_q.size() != 0 && !wr_stall) begin
      commit_f = 1;
      commit_r = exp_q[0].r;
      void'(exp_q.pop_front());
    end
  end
  task automatic drive(input bit force_both);
    if (force_both || !alu_valid || got_a) begin
      alu_valid = force_both || ($urandom_range(0, 2) != 0);
      alu_reg = AW'($urandom_range(0, 7));
      alu_data = DW'($urandom);
    end
    if (force_both || !ld_valid || got_l) begin
      ld_valid = force_both || ($urandom_range(0, 2) != 0);
      ld_reg = AW'($urandom_range(0, 7));
      ld_data = DW'($urandom);
    end
    wr_stall = !force_both && ($urandom_range(0, 3) == 0);
    reserve_en = !force_both && ($urandom_range(0, 2) == 0);
    reserve_reg = AW'($urandom_range(0, 7));
    flush = !force_both && ($urandom_range(0, 19) == 0);
    pl_a = (exp_q.size() == 0 || !wr_stall) && alu_valid && (!ld_valid || last_ld);
    pl_l = (exp_q.size() == 0 || !wr_stall) && ld_valid && (!alu_valid || !last_ld);
    exp_ardy = pl_a;
    exp_lrdy = pl_l;
  endtask
  task automatic step();
    @(posedge clk);
    got_a = pl_a;
    got_l = pl_l;
    if (pl_a) exp_q.push_back(wr_t'{r: alu_reg, d: alu_data});
    if (pl_l) exp_q.push_back(wr_t'{r: ld_reg, d: ld_data});
    if (pl_a || pl_l) last_ld = pl_l;
    exp_orph = commit_f && !pend_m[commit_r];
    exp_conf = reserve_en && pend_m[reserve_reg] && !flush && !(commit_f && commit_r == reserve_reg);
    if (flush) for (int i = 0; i < NR; i++) pend_m[i] = 0;
    if (commit_f) pend_m[commit_r] = 0;
    if (reserve_en) pend_m[reserve_reg] = 1;
    #1 drive(0);
  endtask
  initial begin
    rst = 1;
    mon_en = 0;
    {alu_valid, ld_valid, wr_stall, reserve_en, flush} = '0;
    {alu_reg, ld_reg, reserve_reg, alu_data, ld_data} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst wr_en", wr_en, 0);
    chk("rst wr_reg", wr_reg, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst pending_mask", pending_mask, 0);
    chk("rst flags", {reserve_conflict, wb_orphan}, 0);
    rst = 0;
    drive(1);
    mon_en = 1;
    repeat (3000) step();
    for (int i = 0; i < 200 && exp_q.size() == 0; i++) step();
    chk("wr_en before reset", exp_q.size() != 0, 1);
    #2 rst = 1;
    mon_en = 0;
    #1;
    chk("async rst wr_en", wr_en, 0);
    chk("async rst pending_mask", pending_mask, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    drive(1);
    mon_en = 1;
    repeat (300) step();
    @(negedge clk);
    #1 $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the bank register's single write port between two writeback requesters: the ALU result path (req 0) and the memory-load path (req 1).
- Arbitrates the two requesters round-robin and registers the winning write for one cycle.
- Honours a stall from the bank register.
- Keeps a per-register pending scoreboard that the control unit uses to hold issue on RAW hazards.

Parameters:
DATA_W, 16, width of write data
REG_AW, 4, register address width (2**REG_AW registers)

Ports:
clk  in  1  system clock
rst  in  1  reset
alu_valid  in  1  ALU writeback request
alu_reg  in  REG_AW  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU request accepted this cycle
ld_valid  in  1  load writeback request
ld_reg  in  REG_AW  load destination register
ld_data  in  DATA_W  load data
ld_ready  out  1  load request accepted this cycle
wr_stall  in  1  bank register cannot accept a write this cycle
wr_en  out  1  write strobe to bank register
wr_reg  out  REG_AW  write address to bank register
wr_data  out  DATA_W  write data to bank register
reserve_en  in  1  control unit issued an instruction writing reserve_reg
reserve_reg  in  REG_AW  register being reserved
flush  in  1  clear the scoreboard (branch taken)
pending_mask  out  2**REG_AW  bit r set = register r awaiting writeback
reserve_conflict  out  1  one-cycle pulse: reserve of an already-pending register
wb_orphan  out  1  one-cycle pulse: committed write to a non-pending register

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - On reset, wr_en, wr_reg, wr_data, pending_mask, reserve_conflict and wb_orphan all go to 0.
  - last_grant resets to LD, so the ALU wins the first contention.
- Handshake:
  - A transfer occurs when valid && ready on the same rising edge.
  - A requester holds valid and a stable payload until ready.
  - ready is combinational from valid, last_grant and output-stage state. It never depends on the same requester's ready.
- Output stage: a single register with two states.
  - OUT_EMPTY -> OUT_FULL on accept.
  - OUT_FULL -> OUT_EMPTY on commit (wr_en && !wr_stall) with no new accept.
  - OUT_FULL -> OUT_FULL on commit plus a simultaneous accept.
  - wr_en = (state == OUT_FULL).
- can_accept = OUT_EMPTY || !wr_stall.
  - Back-to-back writes sustain one per cycle.
  - While wr_stall is high in OUT_FULL: both readys are 0, and wr_en, wr_reg and wr_data hold.
- Latency: accept at edge N gives wr_en/wr_reg/wr_data valid in cycle N+1.
- Arbitration, when can_accept:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester other than last_grant is granted.
  - last_grant updates only on an actual transfer.
- Same destination register from both requesters: the writes are serialised in grant order, so the later-granted value persists.
- Scoreboard, updated on the clock edge:
  - A commit of register r clears pending_mask[r].
  - reserve_en sets pending_mask[reserve_reg].
  - If both happen to the same register in the same cycle, the set wins.
  - reserve_en on a register already pending (and not being cleared that cycle) leaves the bit at 1 and pulses reserve_conflict.
  - A commit to a register whose bit is 0 pulses wb_orphan. The write still proceeds.
  - flush clears all bits, then the same-cycle reserve_en is applied. flush does not cancel the output stage; the in-flight write still commits.
- Reset mid-operation: an in-flight write is dropped and all state goes to its reset value immediately.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W and REG_AW defaults
  - requester IDs REQ_ALU=0 and REQ_LD=1
  - output-stage state encoding OUT_EMPTY/OUT_FULL
- One sub-module, rr_arb2: a two-input round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Output: one-hot grant[1:0].
  - Holds the last_grant register.

Test Plan:
1. alu_valid=1, alu_reg=3, alu_data=0x1234, other requester idle -> alu_ready=1 that cycle; next cycle wr_en=1, wr_reg=3, wr_data=0x1234; following cycle wr_en=0.
2. Both valid for 4 cycles (ALU reg1/0xAAAA, LD reg2/0x5555) -> grants ALU, LD, ALU, LD; wr_reg sequence is 1, 2, 1, 2 on consecutive cycles.
3. After an accept of reg4/0x00FF, hold wr_stall=1 for 3 cycles -> wr_en=1 with reg4/0x00FF held, both readys 0; on stall release, commit occurs and the pending requester is accepted in that same cycle.
4. reserve_en reg5, then ld writeback to reg5 -> pending_mask[5]=1 until the commit edge, then 0; a repeat with reserve_en reg5 on the commit cycle leaves pending_mask[5]=1.
5. Commit to reg7 with pending_mask[7]=0 -> wb_orphan high for exactly one cycle and the write is performed; reserve_en on reg5 twice without a commit -> reserve_conflict pulse.
6. Assert rst between clock edges while wr_en=1 and pending_mask=0x0021 -> wr_en and pending_mask are 0 immediately; after release, the first contention grants the ALU.
